// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic on both clock domains.
// Functions work on 32-bit values; callers zero-extend and truncate to the pointer width.
package fifo_pkg;

  localparam int unsigned PTR_MAXW = 32;

  function automatic logic [PTR_MAXW-1:0] bin2gray(input logic [PTR_MAXW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Prefix XOR from the MSB down; leading zero-extension bits leave the result unchanged.
  function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] g);
    logic [PTR_MAXW-1:0] b;
    b[PTR_MAXW-1] = g[PTR_MAXW-1];
    for (int i = PTR_MAXW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Gray value the write pointer takes when it is exactly one lap ahead of the read pointer.
  function automatic logic [PTR_MAXW-1:0] full_target(input logic [PTR_MAXW-1:0] rg,
                                                       input int unsigned aw);
    return rg ^ (PTR_MAXW'(2'b11) << (aw - 1));
  endfunction

  function automatic logic ptr_match(input logic [PTR_MAXW-1:0] a, input logic [PTR_MAXW-1:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter of configurable width.
module fifo_gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/wptr_full.sv
// Write-domain pointer, full/almost-full, level and sticky overflow for the async FIFO.
module wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE  = 4,
  parameter int AF_THRESH = 12
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr_sync,
  input  logic                ovf_clr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                full,
  output logic                almost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                overflow
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);

  logic [PW-1:0] wbin, wbin_next, wgray_next, rbin_sync, level_next;
  logic          full_next;

  fifo_gray2bin #(.W(PW)) u_rg2b (
    .gray (rptr_sync),
    .bin  (rbin_sync)
  );

  assign wen        = winc & ~full;
  assign waddr      = wbin[ADDRSIZE-1:0];
  assign wbin_next  = wbin + PW'(wen);
  assign wgray_next = PW'(bin2gray(PTR_MAXW'(wbin_next)));
  assign level_next = wbin_next - rbin_sync;
  // Uses the lagging read pointer, so full/level can only be overstated, never understated.
  assign full_next  = ptr_match(PTR_MAXW'(wgray_next),
                                full_target(PTR_MAXW'(rptr_sync), ADDRSIZE));

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin        <= '0;
      wptr        <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wlevel      <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wptr        <= wgray_next;
      full        <= full_next;
      almost_full <= level_next >= AF_T;
      wlevel      <= level_next;
      // Set has priority over clear.
      if (winc && full)  overflow <= 1'b1;
      else if (ovf_clr)  overflow <= 1'b0;
    end
  end

endmodule
